pwm_servo_multi: RTL and testbench

PWM_SERVO_MULTI -- requirements
Module: pwm_servo_multi

---
 rtl/pwm_servo_multi.sv | 155 +++++++++++++++
 tb/tb_pwm_servo_multi.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_servo_multi.sv
// Multi-channel hobby-servo PWM generator with an Avalon-MM register file.
// Pulse widths and enables only change on the frame boundary, so a pulse in flight is never cut short.
module pwm_servo_multi #(
   parameter int NUM_CH = 4,
   parameter int PERIOD = 1000000,
   parameter int PW_W   = 20,
   parameter int MIN_PW = 50000,
   parameter int MAX_PW = 100000,
   parameter int CTR_PW = 75000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [3:0]        avs_address,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic              avs_read,
   output logic [31:0]       avs_readdata,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              frame_tick
);

   localparam logic [PW_W-1:0] LAST_CNT = PW_W'(PERIOD - 1);
   localparam logic [PW_W-1:0] CTR_V    = PW_W'(CTR_PW);
   localparam logic [31:0]     MIN_W    = 32'(MIN_PW);
   localparam logic [31:0]     MAX_W    = 32'(MAX_PW);

   logic                          run_q, run_d;
   logic [PW_W-1:0]               cnt_q, cnt_d;
   logic                          tick_q, tick_d;
   logic [NUM_CH-1:0]             enable_q, enable_d;
   logic [NUM_CH-1:0]             shadow_q, shadow_d;
   logic [PW_W-1:0]               step_q, step_d;
   logic [NUM_CH-1:0]             pwm_q, pwm_d;
   logic [31:0]                   rdata_q, rdata_d;
   logic [NUM_CH-1:0]             busy;
   logic [NUM_CH-1:0][PW_W-1:0]   target_all;
   logic [PW_W-1:0]               wr_clamped;
   logic                          boundary;

   assign boundary = run_q && (cnt_q == LAST_CNT);

   always_comb begin
      if (avs_writedata < MIN_W) begin
         wr_clamped = PW_W'(MIN_W);
      end else if (avs_writedata > MAX_W) begin
         wr_clamped = PW_W'(MAX_W);
      end else begin
         wr_clamped = avs_writedata[PW_W-1:0];
      end
   end

   // run_q holds cnt at 0 for the first edge after reset so the first frame starts there.
   always_comb begin
      run_d    = 1'b1;
      cnt_d    = '0;
      if (run_q && (cnt_q != LAST_CNT)) begin
         cnt_d = cnt_q + 1'b1;
      end
      tick_d   = (cnt_d == '0);
      enable_d = enable_q;
      step_d   = step_q;
      if (avs_write && (avs_address == 4'd0)) begin
         enable_d = avs_writedata[NUM_CH-1:0];
      end
      if (avs_write && (avs_address == 4'd1)) begin
         step_d = avs_writedata[PW_W-1:0];
      end
      shadow_d = boundary ? enable_q : shadow_q;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [PW_W-1:0] target_q, target_d;
         logic [PW_W-1:0] active_q, active_d;
         logic [PW_W-1:0] diff;
         logic [PW_W-1:0] stepped;
         logic            up;

         always_comb begin
            up      = target_q > active_q;
            diff    = up ? (target_q - active_q) : (active_q - target_q);
            stepped = target_q;
            if ((step_q != '0) && (diff > step_q)) begin
               stepped = up ? (active_q + step_q) : (active_q - step_q);
            end
            active_d = boundary ? stepped : active_q;
            target_d = target_q;
            if (avs_write && (avs_address == 4'(8 + gi))) begin
               target_d = wr_clamped;
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               target_q <= CTR_V;
               active_q <= CTR_V;
            end else begin
               target_q <= target_d;
               active_q <= active_d;
            end
         end

         assign target_all[gi] = target_q;
         assign busy[gi]       = (active_q != target_q);
         assign pwm_d[gi]      = shadow_q[gi] && (cnt_q < active_q);
      end
   endgenerate

   // Read data is taken from current register values, so a same-cycle write is not visible yet.
   always_comb begin
      rdata_d = '0;
      if (avs_read) begin
         if (avs_address == 4'd0) begin
            rdata_d[NUM_CH-1:0] = enable_q;
         end else if (avs_address == 4'd1) begin
            rdata_d[PW_W-1:0] = step_q;
         end else if (avs_address == 4'd2) begin
            rdata_d[NUM_CH-1:0] = busy;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (avs_address == 4'(8 + i)) begin
               rdata_d[PW_W-1:0] = target_all[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_q    <= 1'b0;
         cnt_q    <= '0;
         tick_q   <= 1'b0;
         enable_q <= '0;
         shadow_q <= '0;
         step_q   <= '0;
         pwm_q    <= '0;
         rdata_q  <= '0;
      end else begin
         run_q    <= run_d;
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
         enable_q <= enable_d;
         shadow_q <= shadow_d;
         step_q   <= step_d;
         pwm_q    <= pwm_d;
         rdata_q  <= rdata_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign frame_tick   = tick_q;
   assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_pwm_servo_multi.sv
// Scoreboard bench for pwm_servo_multi on a shortened frame (PERIOD=1000, widths scaled by 1/1000).
module tb_pwm_servo_multi;

   localparam int NUM_CH = 4;
   localparam int PERIOD = 1000;
   localparam int PW_W   = 12;
   localparam int MIN_PW = 50;
   localparam int MAX_PW = 100;
   localparam int CTR_PW = 75;

   logic              clk;
   logic              reset_n;
   logic [3:0]        avs_address;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic              avs_read;
   logic [31:0]       avs_readdata;
   logic [NUM_CH-1:0] pwm_out;
   logic              frame_tick;

   int checks   = 0;
   int failures = 0;
   int exp_q[$];
   int key_q[$];
   int meas[4][NUM_CH];
   int ticks[4];

   pwm_servo_multi #(
      .NUM_CH(NUM_CH), .PERIOD(PERIOD), .PW_W(PW_W),
      .MIN_PW(MIN_PW), .MAX_PW(MAX_PW), .CTR_PW(CTR_PW)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
      .avs_read(avs_read), .avs_readdata(avs_readdata),
      .pwm_out(pwm_out), .frame_tick(frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_tick(output bit ok);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_tick && n < 2 * PERIOD + 10);
      ok = frame_tick;
   endtask

   // Counts high cycles per channel over n whole frames starting at the next frame_tick.
   task automatic measure_frames(input int n);
      bit ok;
      wait_tick(ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL frame_tick_timeout actual=no tick required=tick within %0d cycles", 2 * PERIOD + 10);
      end
      for (int f = 0; f < n; f++) begin
         ticks[f] = 0;
         for (int c = 0; c < NUM_CH; c++) meas[f][c] = 0;
         for (int s = 0; s < PERIOD; s++) begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) if (pwm_out[c]) meas[f][c]++;
            if (frame_tick) ticks[f]++;
         end
      end
   endtask

   task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
      @(negedge clk);
      avs_address   = addr;
      avs_writedata = data;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_write     = 1'b0;
      $display("write addr=%0d data=0x%08h", addr, data);
   endtask

   task automatic write_at(input int offset, input logic [3:0] addr, input logic [31:0] data);
      bit ok;
      wait_tick(ok);
      repeat (offset) @(negedge clk);
      avs_address   = addr;
      avs_writedata = data;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_write     = 1'b0;
      $display("write addr=%0d data=0x%08h at cnt=%0d", addr, data, offset);
   endtask

   task automatic read_reg(input logic [3:0] addr, output logic [31:0] d);
      @(negedge clk);
      avs_address = addr;
      avs_read    = 1'b1;
      @(negedge clk);
      avs_read    = 1'b0;
      d = avs_readdata;
      $display("read  addr=%0d data=0x%08h", addr, d);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int e;
      int addrs[9] = '{0, 1, 2, 3, 8, 9, 10, 11, 15};
      int exps[9]  = '{0, 0, 0, 0, CTR_PW, CTR_PW, CTR_PW, CTR_PW, 0};
      reset_n = 1'b0; avs_write = 1'b0; avs_read = 1'b0;
      avs_address = '0; avs_writedata = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (pwm_out !== '0) begin failures++; $display("FAIL reset_pwm actual=%b required=0", pwm_out); end
      checks++;
      if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick actual=%b required=0", frame_tick); end
      checks++;
      if (avs_readdata !== '0) begin failures++; $display("FAIL reset_rdata actual=%0h required=0", avs_readdata); end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (frame_tick !== 1'b1) begin failures++; $display("FAIL first_edge_tick actual=%b required=1", frame_tick); end
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(exps[i]);
         read_reg(4'(addrs[i]), d);
         e = exp_q.pop_front();
         checks++;
         if (d !== 32'(e)) begin
            failures++;
            $display("FAIL reset_read addr=%0d actual=%0d required=%0d", addrs[i], d, e);
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin exp_q.push_back(0); key_q.push_back(c); end
      measure_frames(1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); d = 32'(key_q.pop_front());
         checks++;
         if (meas[d / 8][d % 8] !== e) begin
            failures++;
            $display("FAIL reset_idle_width ch%0d actual=%0d required=%0d", d % 8, meas[d / 8][d % 8], e);
         end
      end
   endtask

   task automatic test_enable();
      int e, k;
      write_reg(4'd0, 32'hF);
      for (int f = 0; f < 2; f++)
         for (int c = 0; c < NUM_CH; c++) begin exp_q.push_back(CTR_PW); key_q.push_back(f * 8 + c); end
      measure_frames(2);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); k = key_q.pop_front();
         checks++;
         if (meas[k / 8][k % 8] !== e) begin
            failures++;
            $display("FAIL enable_width frame%0d ch%0d actual=%0d required=%0d", k / 8, k % 8, meas[k / 8][k % 8], e);
         end
      end
      for (int f = 0; f < 2; f++) begin
         checks++;
         if (ticks[f] !== 1) begin failures++; $display("FAIL tick_per_frame frame%0d actual=%0d required=1", f, ticks[f]); end
      end
   endtask

   task automatic test_clamp();
      logic [31:0] d;
      int e, k;
      int widths[NUM_CH] = '{MIN_PW, MAX_PW, CTR_PW, CTR_PW};
      write_reg(4'd8, 32'd10);
      write_reg(4'd9, 32'd200);
      exp_q.push_back(MIN_PW); read_reg(4'd8, d); e = exp_q.pop_front();
      checks++;
      if (d !== 32'(e)) begin failures++; $display("FAIL clamp_low_read actual=%0d required=%0d", d, e); end
      exp_q.push_back(MAX_PW); read_reg(4'd9, d); e = exp_q.pop_front();
      checks++;
      if (d !== 32'(e)) begin failures++; $display("FAIL clamp_high_read actual=%0d required=%0d", d, e); end
      exp_q.push_back(3); read_reg(4'd2, d); e = exp_q.pop_front();
      checks++;
      if (d !== 32'(e)) begin failures++; $display("FAIL clamp_status actual=%0h required=%0h", d, e); end
      for (int c = 0; c < NUM_CH; c++) begin exp_q.push_back(widths[c]); key_q.push_back(c); end
      measure_frames(1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); k = key_q.pop_front();
         checks++;
         if (meas[0][k] !== e) begin
            failures++;
            $display("FAIL clamp_width ch%0d actual=%0d required=%0d", k, meas[0][k], e);
         end
      end
   endtask

   task automatic test_step();
      logic [31:0] d;
      int e, k;
      int ch2[3] = '{85, 95, 100};
      write_reg(4'd1, 32'd10);
      write_reg(4'd10, 32'd100);
      exp_q.push_back(4); read_reg(4'd2, d); e = exp_q.pop_front();
      checks++;
      if (d !== 32'(e)) begin failures++; $display("FAIL step_status_busy actual=%0h required=%0h", d, e); end
      for (int f = 0; f < 3; f++) begin
         exp_q.push_back(MIN_PW);  key_q.push_back(f * 8 + 0);
         exp_q.push_back(ch2[f]);  key_q.push_back(f * 8 + 2);
         exp_q.push_back(CTR_PW);  key_q.push_back(f * 8 + 3);
      end
      measure_frames(3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); k = key_q.pop_front();
         checks++;
         if (meas[k / 8][k % 8] !== e) begin
            failures++;
            $display("FAIL step_width frame%0d ch%0d actual=%0d required=%0d", k / 8, k % 8, meas[k / 8][k % 8], e);
         end
      end
      exp_q.push_back(0); read_reg(4'd2, d); e = exp_q.pop_front();
      checks++;
      if (d !== 32'(e)) begin failures++; $display("FAIL step_status_clear actual=%0h required=%0h", d, e); end
      write_reg(4'd1, 32'd0);
   endtask

   // A register write lands at cnt=offset of the next frame while a multi-frame measurement runs.
   task automatic test_midframe(input string name, input int offset, input logic [3:0] addr,
                                input logic [31:0] data, input int ch, input int n,
                                input int w0, input int w1, input int w2);
      int e, k;
      int ws[3];
      ws[0] = w0; ws[1] = w1; ws[2] = w2;
      for (int f = 0; f < n; f++) begin exp_q.push_back(ws[f]); key_q.push_back(f * 8 + ch); end
      fork
         measure_frames(n);
         write_at(offset, addr, data);
      join
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); k = key_q.pop_front();
         checks++;
         if (meas[k / 8][k % 8] !== e) begin
            failures++;
            $display("FAIL %s frame%0d ch%0d actual=%0d required=%0d", name, k / 8, k % 8, meas[k / 8][k % 8], e);
         end
      end
   endtask

   task automatic test_rw_collision();
      logic [31:0] d;
      int e;
      exp_q.push_back(0);
      @(negedge clk);
      avs_address = 4'd1; avs_writedata = 32'd7; avs_write = 1'b1; avs_read = 1'b1;
      @(negedge clk);
      avs_write = 1'b0; avs_read = 1'b0;
      d = avs_readdata; e = exp_q.pop_front();
      $display("read+write addr=1 data=0x%08h", d);
      checks++;
      if (d !== 32'(e)) begin failures++; $display("FAIL collision_prewrite actual=%0d required=%0d", d, e); end
      exp_q.push_back(7); read_reg(4'd1, d); e = exp_q.pop_front();
      checks++;
      if (d !== 32'(e)) begin failures++; $display("FAIL collision_postwrite actual=%0d required=%0d", d, e); end
   endtask

   task automatic test_unmapped();
      logic [31:0] d;
      int e;
      write_reg(4'd2, 32'hFFFF);
      write_reg(4'd12, 32'd77);
      write_reg(4'd1, 32'hFFFF_F003);
      exp_q.push_back(0); read_reg(4'd2, d); e = exp_q.pop_front();
      checks++;
      if (d !== 32'(e)) begin failures++; $display("FAIL ro_status_write actual=%0h required=%0h", d, e); end
      exp_q.push_back(0); read_reg(4'd12, d); e = exp_q.pop_front();
      checks++;
      if (d !== 32'(e)) begin failures++; $display("FAIL unmapped_read actual=%0h required=%0h", d, e); end
      exp_q.push_back(3); read_reg(4'd1, d); e = exp_q.pop_front();
      checks++;
      if (d !== 32'(e)) begin failures++; $display("FAIL step_upper_bits actual=%0h required=%0h", d, e); end
      write_reg(4'd1, 32'd0);
   endtask

   task automatic test_async_reset();
      logic [31:0] d;
      bit ok;
      int e;
      int addrs[7] = '{0, 1, 2, 8, 9, 10, 11};
      int exps[7]  = '{0, 0, 0, CTR_PW, CTR_PW, CTR_PW, CTR_PW};
      wait_tick(ok);
      repeat (40) @(negedge clk);
      checks++;
      if (pwm_out !== 4'b1110) begin failures++; $display("FAIL pre_reset_pwm actual=%b required=1110", pwm_out); end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (pwm_out !== '0) begin failures++; $display("FAIL async_reset_pwm actual=%b required=0", pwm_out); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(exps[i]);
         read_reg(4'(addrs[i]), d);
         e = exp_q.pop_front();
         checks++;
         if (d !== 32'(e)) begin
            failures++;
            $display("FAIL post_reset_read addr=%0d actual=%0d required=%0d", addrs[i], d, e);
         end
      end
      measure_frames(1);
      for (int c = 0; c < NUM_CH; c++) begin
         checks++;
         if (meas[0][c] !== 0) begin
            failures++;
            $display("FAIL post_reset_idle ch%0d actual=%0d required=0", c, meas[0][c]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_enable();
      test_clamp();
      test_step();
      test_midframe("target_midframe", 30, 4'd11, 32'd60, 3, 2, CTR_PW, 60, 0);
      test_midframe("enable_midframe", 30, 4'd0, 32'hE, 0, 2, MIN_PW, 0, 0);
      test_midframe("boundary_write", PERIOD - 1, 4'd9, 32'd60, 1, 3, MAX_PW, MAX_PW, 60);
      test_rw_collision();
      test_unmapped();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
